// File: rtl/audio_fft_framer_if.sv
// audio_fft_framer_if: codec read port and Avalon-ST sink bus of the audio FFT framer.
//   read_ready, readdata_left/right, read : codec sample-pair read handshake
//   sink_ready, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error : FFT sink beat
//   master = framer side, slave = codec/FFT side
interface audio_fft_framer_if;
   logic        read_ready;
   logic [23:0] readdata_left;
   logic [23:0] readdata_right;
   logic        read;
   logic        sink_ready;
   logic        sink_valid;
   logic        sink_sop;
   logic        sink_eop;
   logic [23:0] sink_real;
   logic [23:0] sink_imag;
   logic [1:0]  sink_error;
   modport master (
      input  read_ready, readdata_left, readdata_right, sink_ready,
      output read, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error
   );
   modport slave (
      output read_ready, readdata_left, readdata_right, sink_ready,
      input  read, sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error
   );
endinterface

// File: rtl/audio_fft_framer.sv
// audio_fft_framer: buffers codec samples and emits fixed-length frames to an FFT sink.
//   clk, reset_n : clock, asynchronous active-low reset
//   enable       : capture and emit frames while high
//   chan_sel     : 00 left, 01 right, 1x mono mix
//   overflow     : sticky, a codec sample waited while the buffer was full
//   bus          : codec read port and Avalon-ST sink (master modport)
module audio_fft_framer #(
   parameter int FRAME_LEN  = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [1:0]             chan_sel,
   output logic                   overflow,
   audio_fft_framer_if.master     bus
);
   localparam int CW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
   state_t        state, state_nxt;
   logic          enable_cap;
   logic [23:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          fifo_full, fifo_empty, push, pop, out_load, stall, transfer, go_idle;
   logic [24:0]   mono_sum;
   logic [23:0]   sample, beat_data;
   logic [CW-1:0] cnt, cnt_adv;
   assign fifo_full  = count == (AW+1)'(FIFO_DEPTH);
   assign fifo_empty = count == '0;
   assign transfer   = bus.sink_valid & bus.sink_ready;
   assign stall      = bus.sink_valid & ~bus.sink_ready;
   // position of the beat that occupies the output register after this edge
   assign cnt_adv    = transfer ? (cnt == LAST ? '0 : cnt + 1'b1) : cnt;
   assign mono_sum   = {bus.readdata_left[23], bus.readdata_left} + {bus.readdata_right[23], bus.readdata_right};
   assign sample     = chan_sel == 2'b00 ? bus.readdata_left : chan_sel == 2'b01 ? bus.readdata_right : mono_sum[24:1];
   // an empty buffer while draining pads the frame with zeros
   assign beat_data  = fifo_empty ? '0 : mem[rd_ptr];
   assign go_idle    = state_nxt == IDLE;
   assign bus.read       = push;
   assign bus.sink_imag  = '0;
   assign bus.sink_error = 2'b00;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state      <= IDLE;
         enable_cap <= 1'b0;
      end else begin
         state      <= state_nxt;
         enable_cap <= enable;
      end
   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      out_load  = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE: state_nxt = enable ? STREAM : IDLE;
         STREAM: begin
            push      = bus.read_ready & enable_cap & ~fifo_full;
            out_load  = ~stall & ~fifo_empty;
            pop       = out_load;
            if (!enable) state_nxt = cnt_adv == '0 ? IDLE : DRAIN;
         end
         DRAIN: begin
            out_load  = ~stall & (cnt_adv != '0);
            pop       = out_load & ~fifo_empty;
            if (transfer & bus.sink_eop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= sample;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (go_idle) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         cnt            <= '0;
         bus.sink_valid <= 1'b0;
         bus.sink_sop   <= 1'b0;
         bus.sink_eop   <= 1'b0;
         bus.sink_real  <= '0;
      end else if (go_idle) begin
         cnt            <= '0;
         bus.sink_valid <= 1'b0;
         bus.sink_sop   <= 1'b0;
         bus.sink_eop   <= 1'b0;
         bus.sink_real  <= '0;
      end else begin
         cnt <= cnt_adv;
         if (!stall) begin
            bus.sink_valid <= out_load;
            bus.sink_sop   <= cnt_adv == '0;
            bus.sink_eop   <= cnt_adv == LAST;
            if (out_load) bus.sink_real <= beat_data;
         end
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) overflow <= 1'b0;
      else if (bus.read_ready & enable_cap & fifo_full) overflow <= 1'b1;
endmodule

// File: doc/audio_fft_framer.md
AUDIO_FFT_FRAMER -- requirements
Module: audio_fft_framer

Parameters
REQ-001 FRAME_LEN, 64, samples per FFT frame; power of two, 8..1024.
REQ-002 FIFO_DEPTH, 16, sample buffer entries; power of two, 4..64.

Interface
REQ-003 clk  input  1  single clock for all logic, same domain as codec read interface.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 = capture and emit frames.
REQ-006 chan_sel  input  2  00 left, 01 right, 10 mono mix, 11 treated as 10.
REQ-007 read_ready  input  1  codec holds a sample pair.
REQ-008 readdata_left  input  24  signed left sample.
REQ-009 readdata_right  input  24  signed right sample.
REQ-010 read  output  1  consume one codec sample pair this cycle.
REQ-011 sink_ready  input  1  FFT accepts a beat.
REQ-012 sink_valid  output  1  beat valid.
REQ-013 sink_sop  output  1  first beat of frame.
REQ-014 sink_eop  output  1  last beat of frame.
REQ-015 sink_real  output  24  sample value.
REQ-016 sink_imag  output  24  constant 0.
REQ-017 sink_error  output  2  constant 2'b00.
REQ-018 overflow  output  1  sticky: codec sample waited while FIFO was full.

Function
REQ-019 read SHALL equal read_ready & enable_cap & ~fifo_full, combinationally; enable_cap is the registered enable described in REQ-025.
REQ-020 Sample selection: left = readdata_left; right = readdata_right; mono = 25-bit signed sum of both channels, arithmetic shift right by 1, truncated to 24 bits (no overflow possible).
REQ-021 On a cycle with read=1, the selected sample SHALL be written into the FIFO at the next clk edge.
REQ-022 FIFO: FIFO_DEPTH entries, first-in first-out; simultaneous push and pop when full or empty SHALL be handled correctly (push and pop on an empty FIFO pass the data through with no loss; count unchanged when both occur while non-empty).
REQ-023 Output stage SHALL be a registered Avalon-ST source: sink_valid, sink_sop, sink_eop and sink_real are driven from flops.
REQ-024 While sink_valid=1 and sink_ready=0, all sink_* outputs SHALL hold stable; a beat transfers only on sink_valid & sink_ready at a clk edge.
REQ-025 State machine with states IDLE, STREAM, DRAIN:
- IDLE: read=0, sink_valid=0, beat counter=0; enable sampled to 1 -> STREAM.
- STREAM: capture and emit; enable sampled 0 with beat counter=0 -> IDLE; enable sampled 0 with beat counter!=0 -> DRAIN.
- DRAIN: read=0; emit remaining buffered beats until the beat with sink_eop transfers; then flush FIFO -> IDLE.
REQ-026 In DRAIN, if the FIFO empties before the frame is complete, zero-valued beats SHALL be emitted to finish the frame.
REQ-027 The beat counter SHALL count transferred beats 0..FRAME_LEN-1 and wrap to 0 after the sink_eop beat.
- sink_sop = 1 exactly when counter=0.
- sink_eop = 1 exactly when counter=FRAME_LEN-1.
REQ-028 Latency: with FIFO empty, output empty and sink_ready=1, a sample read at edge N SHALL appear with sink_valid=1 after edge N+2.
REQ-029 Throughput: with sink_ready held at 1, one beat SHALL transfer per cycle while the FIFO is non-empty.
REQ-030 overflow SHALL set at the edge following any cycle with read_ready=1, enable_cap=1 and fifo_full=1; it clears only on reset.
REQ-031 chan_sel changes SHALL take effect on the next read; frame boundaries are unaffected.

Reset
REQ-032 On reset_n=0, asynchronously: state=IDLE, FIFO empty, beat counter=0, sink_valid=0, sink_sop=0, sink_eop=0, sink_real=0, overflow=0, enable_cap=0.
REQ-033 read SHALL be 0 while reset_n=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; the first beat after reset is sink_sop=1.

Verification
REQ-035 FRAME_LEN=8, chan_sel=00, left samples 1..16, sink_ready=1 -> 16 beats with values 1..16; sop on values 1 and 9; eop on values 8 and 16.
REQ-036 chan_sel=10, L=24'h7FFFFF, R=24'h7FFFFF -> sink_real=24'h7FFFFF; L=24'h800000, R=24'h000001 -> sink_real=24'hC00000.
REQ-037 sink_ready=0 for 20 cycles while read_ready=1 continuously -> FIFO fills; outputs hold stable; read drops to 0 and overflow=1; after sink_ready=1, data resumes in order with no duplicate beats.
REQ-038 FRAME_LEN=8, enable deasserted after 3 beats with an empty FIFO -> DRAIN emits 5 zero beats, the last with eop=1 -> IDLE; read stays 0.
REQ-039 reset_n pulsed low on beat 5 of a frame -> all outputs reset immediately; after re-enable, the first beat has sop=1.
REQ-040 Empty pipeline, sink_ready=1, single read at edge N -> sink_valid first high after edge N+2, with sop=1.
